// File: rtl/scm_fifo_pkg.sv
// Shared constants, types and helpers for the SCM-backed FIFO controller.
// Optional feature macro used by the controller: SCM_FIFO_ALMOST_FULL_EN.
package scm_fifo_pkg;

   localparam int unsigned ADDR_WIDTH_DEF = 5;
   localparam int unsigned DATA_WIDTH_DEF = 32;
   // Almost-full defaults to this many entries below a full SCM.
   localparam int unsigned AF_OFFSET      = 1;

   // SCM depth for a given address width, without $clog2 or real math.
   function automatic int unsigned fifo_depth(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

   // Pointer and occupancy types for the default configuration.
   typedef logic [ADDR_WIDTH_DEF-1:0] ptr_def_t;
   typedef logic [ADDR_WIDTH_DEF:0]   cnt_def_t;

endpackage

// File: rtl/scm_fifo_out_stage.sv
// Output register of the FIFO: holds the head word and refills when empty
// or when the consumer takes the current word.
// Ports: clk, rst_n (sync, active-low), clear (sync flush), out_ready_i,
//        fill_valid/fill_data (candidate head word), load_c (refill allowed
//        this cycle, combinational), out_valid_o/out_data_o (registered).
module scm_fifo_out_stage #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  out_ready_i,
   input  logic                  fill_valid,
   input  logic [DATA_WIDTH-1:0] fill_data,
   output logic                  load_c,
   output logic                  out_valid_o,
   output logic [DATA_WIDTH-1:0] out_data_o
);

   assign load_c = !out_valid_o || out_ready_i;

   // Head register; data holds its last value when nothing refills it.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
      end else if (load_c) begin
         out_valid_o <= fill_valid;
         if (fill_valid) out_data_o <= fill_data;
      end
   end

endmodule

// File: rtl/scm_fifo_ctrl.sv
// Valid/ready FIFO controller driving a 1R/1W flop-based SCM with
// combinational read, plus a registered output stage (capacity DEPTH+1).
// Ports: clk, rst_n (sync, active-low), clear_i (sync flush),
//        in_valid_i/in_ready_o/in_data_i (push side),
//        out_valid_o/out_ready_i/out_data_o (pop side), count_o (occupancy),
//        WriteEnable/WriteAddr/WriteData and ReadEnable/ReadAddr/ReadData
//        (SCM interface), almost_full_o (only with SCM_FIFO_ALMOST_FULL_EN).
module scm_fifo_ctrl
   import scm_fifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF
`ifdef SCM_FIFO_ALMOST_FULL_EN
   ,
   parameter int unsigned AF_THRESHOLD = fifo_depth(ADDR_WIDTH) - AF_OFFSET
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic [ADDR_WIDTH:0]   count_o,
   output logic                  WriteEnable,
   output logic [ADDR_WIDTH-1:0] WriteAddr,
   output logic [DATA_WIDTH-1:0] WriteData,
   output logic                  ReadEnable,
   output logic [ADDR_WIDTH-1:0] ReadAddr,
   input  logic [DATA_WIDTH-1:0] ReadData
`ifdef SCM_FIFO_ALMOST_FULL_EN
   ,
   output logic                  almost_full_o
`endif
);

   localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

   typedef logic [ADDR_WIDTH-1:0] ptr_t;
   typedef logic [ADDR_WIDTH:0]   cnt_t;

   ptr_t wr_ptr, rd_ptr;
   cnt_t scm_cnt, scm_cnt_nxt;
   logic load_c, push, bypass, wr_en, rd_en, fill_valid, scm_empty;
   logic [DATA_WIDTH-1:0] fill_data;

   assign scm_empty  = (scm_cnt == '0);
   // No path from out_ready_i: readiness depends only on SCM occupancy.
   assign in_ready_o = !clear_i && (scm_cnt < cnt_t'(DEPTH));
   assign push       = in_valid_i && in_ready_o;

   // Refill and write decisions; SCM head has priority over the bypass.
   always_comb begin
      bypass      = 1'b0;
      rd_en       = 1'b0;
      wr_en       = 1'b0;
      fill_valid  = !scm_empty || push;
      fill_data   = in_data_i;
      scm_cnt_nxt = scm_cnt;
      if (rst_n && !clear_i) begin
         if (load_c && !scm_empty) begin
            rd_en     = 1'b1;
            fill_data = ReadData;
         end
         bypass = load_c && scm_empty && push;
         wr_en  = push && !bypass;
         case ({wr_en, rd_en})
            2'b10:   scm_cnt_nxt = scm_cnt + cnt_t'(1);
            2'b01:   scm_cnt_nxt = scm_cnt - cnt_t'(1);
            default: scm_cnt_nxt = scm_cnt;
         endcase
      end
   end

   // Pointers wrap naturally at DEPTH; reset and clear empty the SCM view.
   always_ff @(posedge clk) begin
      if (!rst_n || clear_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         scm_cnt <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + ptr_t'(1);
         if (rd_en) rd_ptr <= rd_ptr + ptr_t'(1);
         scm_cnt <= scm_cnt_nxt;
      end
   end

   scm_fifo_out_stage #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear_i),
      .out_ready_i (out_ready_i),
      .fill_valid  (fill_valid),
      .fill_data   (fill_data),
      .load_c      (load_c),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o)
   );

   // Addresses are the pointers, so they hold whenever the enables are low.
   assign WriteEnable = wr_en;
   assign WriteAddr   = wr_ptr;
   assign WriteData   = in_data_i;
   assign ReadEnable  = rd_en;
   assign ReadAddr    = rd_ptr;
   assign count_o     = scm_cnt + cnt_t'(out_valid_o);

`ifdef SCM_FIFO_ALMOST_FULL_EN
   // Registered flag tracking the occupancy the SCM will have next cycle.
   always_ff @(posedge clk) begin
      if (!rst_n || clear_i) almost_full_o <= 1'b0;
      else                   almost_full_o <= (scm_cnt_nxt >= cnt_t'(AF_THRESHOLD));
   end
`endif

endmodule

// File: tb/tb_scm_fifo_ctrl.sv
// Directed self-checking bench for scm_fifo_ctrl with ADDR_WIDTH=2 (DEPTH 4,
// capacity 5) and an 8-bit payload; includes a behavioural SCM array.
module tb_scm_fifo_ctrl;

   localparam int unsigned AW = 2;
   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst_n, clear_i, in_valid_i, out_ready_i;
   logic          in_ready_o, out_valid_o;
   logic [DW-1:0] in_data_i, out_data_o;
   logic [AW:0]   count_o;
   logic          WriteEnable, ReadEnable;
   logic [AW-1:0] WriteAddr, ReadAddr;
   logic [DW-1:0] WriteData, ReadData;
`ifdef SCM_FIFO_ALMOST_FULL_EN
   logic          almost_full_o;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   logic [DW-1:0] scm_mem [4];
   logic [DW-1:0] q [$];

   always #5 clk = ~clk;

   // SCM model: registered write, combinational read.
   always @(posedge clk) if (WriteEnable) scm_mem[WriteAddr] <= WriteData;
   assign ReadData = scm_mem[ReadAddr];

   scm_fifo_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
`ifdef SCM_FIFO_ALMOST_FULL_EN
      ,
      .AF_THRESHOLD (3)
`endif
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (clear_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .count_o     (count_o),
      .WriteEnable (WriteEnable),
      .WriteAddr   (WriteAddr),
      .WriteData   (WriteData),
      .ReadEnable  (ReadEnable),
      .ReadAddr    (ReadAddr),
      .ReadData    (ReadData)
`ifdef SCM_FIFO_ALMOST_FULL_EN
      ,
      .almost_full_o (almost_full_o)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear_i = 1'b0; in_valid_i = 1'b1; in_data_i = 8'h33; out_ready_i = 1'b0;
      repeat (3) step();
      #1;
      n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid_o); end
      n_cmp++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count_o); end
      n_cmp++; if (WriteEnable !== 1'b0) begin n_fail++; $display("FAIL reset_wen got %0b want 0", WriteEnable); end
      n_cmp++; if (ReadEnable !== 1'b0) begin n_fail++; $display("FAIL reset_ren got %0b want 0", ReadEnable); end
      n_cmp++; if (out_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", out_data_o); end
      rst_n = 1'b1; in_valid_i = 1'b0;
      #1;
      n_cmp++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready_o); end
      step();
   endtask

   task automatic test_bypass();
      in_valid_i = 1'b1; in_data_i = 8'hA5; out_ready_i = 1'b0;
      #1;
      n_cmp++; if (WriteEnable !== 1'b0) begin n_fail++; $display("FAIL bypass_wen got %0b want 0", WriteEnable); end
      step();
      in_valid_i = 1'b0;
      #1;
      n_cmp++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL bypass_valid got %0b want 1", out_valid_o); end
      n_cmp++; if (out_data_o !== 8'hA5) begin n_fail++; $display("FAIL bypass_data got %h want a5", out_data_o); end
      n_cmp++; if (count_o !== 3'd1) begin n_fail++; $display("FAIL bypass_count got %0d want 1", count_o); end
      out_ready_i = 1'b1;
      step();
      out_ready_i = 1'b0;
      #1;
      n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL bypass_empty got %0b want 0", out_valid_o); end
      n_cmp++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL bypass_count0 got %0d want 0", count_o); end
   endtask

   task automatic test_fill();
      out_ready_i = 1'b0;
      for (int v = 1; v <= 6; v++) begin
         in_valid_i = 1'b1; in_data_i = DW'(v);
         #1;
         if (v >= 2 && v <= 5) begin
            n_cmp++; if (WriteEnable !== 1'b1) begin n_fail++; $display("FAIL fill_wen v=%0d got %0b want 1", v, WriteEnable); end
            n_cmp++; if (WriteAddr !== AW'(v - 2)) begin n_fail++; $display("FAIL fill_waddr v=%0d got %0d want %0d", v, WriteAddr, v - 2); end
         end
         if (v == 6) begin
            n_cmp++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_ready_full got %0b want 0", in_ready_o); end
            n_cmp++; if (WriteEnable !== 1'b0) begin n_fail++; $display("FAIL fill_wen_full got %0b want 0", WriteEnable); end
         end
         step();
      end
      in_valid_i = 1'b0;
      #1;
      n_cmp++; if (count_o !== 3'd5) begin n_fail++; $display("FAIL fill_count got %0d want 5", count_o); end
      n_cmp++; if (out_data_o !== 8'h01) begin n_fail++; $display("FAIL fill_head got %h want 01", out_data_o); end
   endtask

   task automatic test_drain();
      out_ready_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_cmp++; if (out_valid_o !== 1'b1 || out_data_o !== DW'(k + 1)) begin n_fail++; $display("FAIL drain_data k=%0d got %0b/%h want 1/%h", k, out_valid_o, out_data_o, k + 1); end
         if (k < 4) begin
            n_cmp++; if (ReadEnable !== 1'b1 || ReadAddr !== AW'(k)) begin n_fail++; $display("FAIL drain_raddr k=%0d got %0b/%0d want 1/%0d", k, ReadEnable, ReadAddr, k); end
         end else begin
            n_cmp++; if (ReadEnable !== 1'b0) begin n_fail++; $display("FAIL drain_ren_empty got %0b want 0", ReadEnable); end
         end
         if (k == 0) begin
            n_cmp++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL drain_ready0 got %0b want 0", in_ready_o); end
         end
         if (k == 1) begin
            n_cmp++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL drain_ready1 got %0b want 1", in_ready_o); end
         end
         step();
      end
      out_ready_i = 1'b0;
      #1;
      n_cmp++; if (out_valid_o !== 1'b0 || count_o !== 3'd0) begin n_fail++; $display("FAIL drain_end got %0b/%0d want 0/0", out_valid_o, count_o); end
   endtask

   task automatic test_back_to_back();
      logic [19:0]   rdy_pat;
      logic [DW-1:0] nxt;
      rdy_pat = 20'b1011_0011_1010_0110_1101;
      nxt     = 8'h40;
      q.delete();
      for (int i = 0; i < 20; i++) begin
         in_valid_i = 1'b1; in_data_i = nxt; out_ready_i = rdy_pat[i];
         #1;
         n_cmp++; if (count_o !== 3'(q.size()) || count_o > 3'd5) begin n_fail++; $display("FAIL b2b_count i=%0d got %0d want %0d", i, count_o, q.size()); end
         if (WriteEnable && ReadEnable) begin
            n_cmp++; if (WriteAddr === ReadAddr) begin n_fail++; $display("FAIL b2b_addr_clash i=%0d got %0d want !=%0d", i, WriteAddr, ReadAddr); end
         end
         if (out_valid_o && out_ready_i) begin
            n_cmp++; if (q.size() == 0 || out_data_o !== q[0]) begin n_fail++; $display("FAIL b2b_order i=%0d got %h want %h", i, out_data_o, (q.size() != 0) ? q[0] : 8'hxx); end
            if (q.size() != 0) void'(q.pop_front());
         end
         if (in_ready_o) begin
            q.push_back(nxt);
            nxt = nxt + 8'd1;
         end
         step();
      end
      in_valid_i = 1'b0; out_ready_i = 1'b1;
      for (int i = 0; i < 8 && q.size() != 0; i++) begin
         #1;
         n_cmp++; if (out_valid_o !== 1'b1 || out_data_o !== q[0]) begin n_fail++; $display("FAIL b2b_drain got %0b/%h want 1/%h", out_valid_o, out_data_o, q[0]); end
         void'(q.pop_front());
         step();
      end
      out_ready_i = 1'b0;
      #1;
      n_cmp++; if (q.size() != 0 || count_o !== 3'd0) begin n_fail++; $display("FAIL b2b_final got %0d left/count %0d want 0/0", q.size(), count_o); end
   endtask

   task automatic test_clear();
      out_ready_i = 1'b0;
      for (int v = 0; v < 3; v++) begin
         in_valid_i = 1'b1; in_data_i = DW'(8'h10 + v);
         step();
      end
      #1;
      n_cmp++; if (count_o !== 3'd3) begin n_fail++; $display("FAIL clear_pre_count got %0d want 3", count_o); end
      clear_i = 1'b1; in_valid_i = 1'b1; in_data_i = 8'h99; out_ready_i = 1'b1;
      #1;
      n_cmp++; if (in_ready_o !== 1'b0 || WriteEnable !== 1'b0 || ReadEnable !== 1'b0) begin n_fail++; $display("FAIL clear_gating got rdy%0b/we%0b/re%0b want 0/0/0", in_ready_o, WriteEnable, ReadEnable); end
      step();
      clear_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
      #1;
      n_cmp++; if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin n_fail++; $display("FAIL clear_post got %0d/%0b want 0/0", count_o, out_valid_o); end
`ifdef SCM_FIFO_ALMOST_FULL_EN
      n_cmp++; if (almost_full_o !== 1'b0) begin n_fail++; $display("FAIL af_after_clear got %0b want 0", almost_full_o); end
`endif
      // Four pushes: one bypass, then three SCM writes.
      for (int v = 0; v < 4; v++) begin
         in_valid_i = 1'b1; in_data_i = DW'(8'h20 + v);
         step();
`ifdef SCM_FIFO_ALMOST_FULL_EN
         #1;
         n_cmp++; if (almost_full_o !== (v == 3)) begin n_fail++; $display("FAIL af_push v=%0d got %0b want %0b", v, almost_full_o, (v == 3)); end
`endif
      end
      in_valid_i = 1'b0;
      #1;
      n_cmp++; if (out_data_o !== 8'h20 || count_o !== 3'd4) begin n_fail++; $display("FAIL clear_refill got %h/%0d want 20/4", out_data_o, count_o); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; clear_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; in_data_i = '0;
      test_reset();
      test_bypass();
      test_fill();
      test_drain();
      test_back_to_back();
      test_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
